// File: rtl/pipe_pkg.sv
// Shared constants for the EX/MEM pipeline boundary.
// Provides bus widths, the bit position of every field inside the packed
// control and payload buses, and the occupancy state encoding used by the
// two-entry skid stage.
package pipe_pkg;

  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 101;

  // Control bus field positions
  localparam int CTRL_JUMPLINK_BIT = 0;
  localparam int CTRL_MEMWRITE_BIT = 1;
  localparam int CTRL_MEMTOREG_BIT = 2;
  localparam int CTRL_REGWRITE_BIT = 3;

  // Payload bus field positions (LSB of each field)
  localparam int DATA_PCPLUS4_LSB   = 0;   // 32 bits
  localparam int DATA_WRITEREG_LSB  = 32;  // 5 bits
  localparam int DATA_WRITEDATA_LSB = 37;  // 32 bits
  localparam int DATA_ALUOUT_LSB    = 69;  // 32 bits

  // Occupancy encoding doubles as the occupancy output value
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the pipeline stage: valid flag, control bits, payload.
// Ports:
//   clk, reset   - clock and synchronous active-high reset (clears everything)
//   clear        - drop the entry (valid and control cleared, payload kept)
//   load         - capture in_ctrl/in_data and mark the entry valid
//   in_ctrl/in_data - entry contents to capture
//   valid/ctrl/data - currently held entry
// clear has priority over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register for the EX/MEM boundary.
// SKID=1: two-entry skid stage, in_ready comes straight from a register so
//         there is no combinational path from out_ready to in_ready.
// SKID=0: single-entry stall register, in_ready = !out_valid || out_ready.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - upstream handshake, in_ctrl/in_data offered entry
//   flush               - discard every held entry and any entry offered now
//   out_valid/out_ready - downstream handshake, out_ctrl/out_data head entry
//   occupancy           - number of held entries (0..2)
// out_ctrl is forced to zero when no entry is held so a bubble never
// asserts regwrite or memwrite downstream.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  if (SKID != 0) begin : g_skid
    occ_state_e        state, next_state;
    logic              ready_q;
    logic              accept, consume;
    logic              head_load, head_clear, skid_load, skid_clear;
    logic [CTRL_W-1:0] head_in_ctrl;
    logic [DATA_W-1:0] head_in_data;
    logic              head_valid, skid_valid;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic [DATA_W-1:0] head_data, skid_data;

    assign accept  = in_valid && ready_q;
    assign consume = head_valid && out_ready;

    // State register; in_ready is registered from the next state
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= OCC_EMPTY;
        ready_q <= 1'b1;
      end else begin
        state   <= next_state;
        ready_q <= (next_state != OCC_TWO);
      end
    end

    always_comb begin
      next_state = state;
      if (flush) begin
        next_state = OCC_EMPTY;
      end else begin
        case (state)
          OCC_EMPTY: if (accept) next_state = OCC_ONE;
          OCC_ONE: begin
            if (accept && !consume)      next_state = OCC_TWO;
            else if (!accept && consume) next_state = OCC_EMPTY;
          end
          OCC_TWO:   if (consume) next_state = OCC_ONE;
          default:   next_state = OCC_EMPTY;
        endcase
      end
    end

    // Slot steering: head is always the oldest entry; the skid slot only
    // fills when the head is stalled, and is promoted when the head leaves.
    always_comb begin
      head_load    = 1'b0;
      head_clear   = 1'b0;
      skid_load    = 1'b0;
      skid_clear   = 1'b0;
      head_in_ctrl = in_ctrl;
      head_in_data = in_data;
      if (flush) begin
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state)
          OCC_EMPTY: head_load = accept;
          OCC_ONE: begin
            if (consume) begin
              head_load  = accept;
              head_clear = !accept;
            end else begin
              skid_load  = accept;
            end
          end
          OCC_TWO: begin
            if (consume) begin
              head_load    = 1'b1;
              head_in_ctrl = skid_ctrl;
              head_in_data = skid_data;
              skid_clear   = 1'b1;
            end
          end
          default: begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
      .clk     (clk),
      .reset   (reset),
      .clear   (head_clear),
      .load    (head_load),
      .in_ctrl (head_in_ctrl),
      .in_data (head_in_data),
      .valid   (head_valid),
      .ctrl    (head_ctrl),
      .data    (head_data)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear   (skid_clear),
      .load    (skid_load),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
    );

    assign in_ready  = ready_q;
    assign out_valid = head_valid;
    assign out_ctrl  = head_valid ? head_ctrl : '0;
    assign out_data  = head_data;
    assign occupancy = state;

  end else begin : g_single
    logic              accept, consume;
    logic              slot_valid;
    logic [CTRL_W-1:0] slot_ctrl;
    logic [DATA_W-1:0] slot_data;

    assign in_ready = !slot_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = slot_valid && out_ready;

    // Accept and consume together simply overwrite the slot
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush || (consume && !accept)),
      .load    (accept),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .valid   (slot_valid),
      .ctrl    (slot_ctrl),
      .data    (slot_data)
    );

    assign out_valid = slot_valid;
    assign out_ctrl  = slot_valid ? slot_ctrl : '0;
    assign out_data  = slot_data;
    assign occupancy = {1'b0, slot_valid};
  end

endmodule
